mem_perf_monitor: RTL and testbench

//  Passive snooper on the cluster-to-memory request/response handshake.

---
 rtl/mem_perf_monitor.sv | 128 ++++++++++++
 tb/tb_mem_perf_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_perf_monitor.sv
// Passive memory-side performance counters snooping the request/response handshake.
// Optional duplicate-read window enabled by defining MEM_PERF_DUP_EN.
module mem_perf_monitor #(
    parameter int PERF_CTR_BITS = 44,
    parameter int ADDR_WIDTH    = 26,
    parameter int PENDING_BITS  = 8,
    parameter int DUP_ENTRIES   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    input  logic                     mem_req_rw,
    input  logic [ADDR_WIDTH-1:0]    mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic                     mem_rsp_ready,
    output logic [PERF_CTR_BITS-1:0] mem_reads,
    output logic [PERF_CTR_BITS-1:0] mem_writes,
    output logic [PERF_CTR_BITS-1:0] mem_latency,
    output logic [PERF_CTR_BITS-1:0] mem_dup,
    output logic [PENDING_BITS-1:0]  pending_reads,
    output logic                     perf_err
);

    // Latency sum is formed at the wider of the two widths, then wrapped.
    localparam int LAT_W = (PERF_CTR_BITS > PENDING_BITS) ? PERF_CTR_BITS : PENDING_BITS;
    localparam logic [PENDING_BITS-1:0] PEND_MAX = '1;
    localparam logic [PENDING_BITS-1:0] PEND_ONE = PENDING_BITS'(1);

    logic req_fire, rsp_fire, rd_fire, wr_fire;

    logic [PERF_CTR_BITS-1:0] reads_q, reads_d;
    logic [PERF_CTR_BITS-1:0] writes_q, writes_d;
    logic [PERF_CTR_BITS-1:0] latency_q, latency_d;
    logic [PENDING_BITS-1:0]  pending_q, pending_d;
    logic                     err_q, err_d;

    always_comb begin
        req_fire  = mem_req_valid & mem_req_ready;
        rsp_fire  = mem_rsp_valid & mem_rsp_ready;
        rd_fire   = req_fire & ~mem_req_rw;
        wr_fire   = req_fire & mem_req_rw;

        reads_d   = reads_q  + PERF_CTR_BITS'(rd_fire);
        writes_d  = writes_q + PERF_CTR_BITS'(wr_fire);
        latency_d = PERF_CTR_BITS'(LAT_W'(latency_q) + LAT_W'(pending_q));

        pending_d = pending_q;
        err_d     = err_q;
        // A read and a response in the same cycle cancel, even at zero pending.
        if (rd_fire && !rsp_fire) begin
            if (pending_q != PEND_MAX) pending_d = pending_q + PEND_ONE;
        end else if (rsp_fire && !rd_fire) begin
            if (pending_q != '0) pending_d = pending_q - PEND_ONE;
            else                 err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reads_q   <= '0;
            writes_q  <= '0;
            latency_q <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            reads_q   <= reads_d;
            writes_q  <= writes_d;
            latency_q <= latency_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

`ifdef MEM_PERF_DUP_EN
    localparam int PTR_W = (DUP_ENTRIES > 1) ? $clog2(DUP_ENTRIES) : 1;

    logic [ADDR_WIDTH-1:0]    win_addr_q [DUP_ENTRIES];
    logic [ADDR_WIDTH-1:0]    win_addr_d [DUP_ENTRIES];
    logic [DUP_ENTRIES-1:0]   win_vld_q, win_vld_d;
    logic [PTR_W-1:0]         wptr_q, wptr_d;
    logic [PERF_CTR_BITS-1:0] dup_q, dup_d;
    logic                     hit;

    always_comb begin
        win_addr_d = win_addr_q;
        win_vld_d  = win_vld_q;
        wptr_d     = wptr_q;
        hit        = 1'b0;
        // Lookup sees the window before this read is inserted.
        for (int i = 0; i < DUP_ENTRIES; i++) begin
            if (win_vld_q[i] && (win_addr_q[i] == mem_req_addr)) hit = 1'b1;
        end
        dup_d = dup_q + PERF_CTR_BITS'(rd_fire & hit);
        if (rd_fire) begin
            win_addr_d[wptr_q] = mem_req_addr;
            win_vld_d[wptr_q]  = 1'b1;
            wptr_d = (wptr_q == PTR_W'(DUP_ENTRIES - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        win_addr_q <= win_addr_d;
        if (reset) begin
            win_vld_q <= '0;
            wptr_q    <= '0;
            dup_q     <= '0;
        end else begin
            win_vld_q <= win_vld_d;
            wptr_q    <= wptr_d;
            dup_q     <= dup_d;
        end
    end

    assign mem_dup = dup_q;
`else
    logic unused_addr;
    assign unused_addr = ^mem_req_addr;
    assign mem_dup     = '0;
`endif

    assign mem_reads     = reads_q;
    assign mem_writes    = writes_q;
    assign mem_latency   = latency_q;
    assign pending_reads = pending_q;
    assign perf_err      = err_q;

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Bench for mem_perf_monitor: directed table, corner sequences, random vs reference model.
// Drives a default-width instance and a narrow (4-bit counter, 3-bit pending) instance.
module tb_mem_perf_monitor;

    localparam int AW = 26;
    localparam int DUP_N = 4;

    logic          clk = 1'b0;
    logic          reset, req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
    logic [AW-1:0] req_addr;

    logic [43:0] reads_b, writes_b, lat_b, dup_b;
    logic [7:0]  pend_b;
    logic        err_b;
    logic [3:0]  reads_s, writes_s, lat_s, dup_s;
    logic [2:0]  pend_s;
    logic        err_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_perf_monitor u_big (
        .clk(clk), .reset(reset),
        .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_rw(req_rw),
        .mem_req_addr(req_addr), .mem_rsp_valid(rsp_valid), .mem_rsp_ready(rsp_ready),
        .mem_reads(reads_b), .mem_writes(writes_b), .mem_latency(lat_b),
        .mem_dup(dup_b), .pending_reads(pend_b), .perf_err(err_b)
    );

    mem_perf_monitor #(.PERF_CTR_BITS(4), .PENDING_BITS(3)) u_small (
        .clk(clk), .reset(reset),
        .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_rw(req_rw),
        .mem_req_addr(req_addr), .mem_rsp_valid(rsp_valid), .mem_rsp_ready(rsp_ready),
        .mem_reads(reads_s), .mem_writes(writes_s), .mem_latency(lat_s),
        .mem_dup(dup_s), .pending_reads(pend_s), .perf_err(err_s)
    );

    // Reference model: unbounded counts, masked to each instance's width on compare.
    longint unsigned m_reads, m_writes, m_dup;
    longint unsigned m_lat [2];
    int              m_pend [2];
    bit              m_err [2];
    logic [AW-1:0]   m_win [$];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit rd, wr, rsp, hit;
        rd  = req_valid && req_ready && !req_rw;
        wr  = req_valid && req_ready && req_rw;
        rsp = rsp_valid && rsp_ready;
        if (reset) begin
            m_reads = 0; m_writes = 0; m_dup = 0;
            for (int k = 0; k < 2; k++) begin
                m_lat[k] = 0; m_pend[k] = 0; m_err[k] = 0;
            end
            m_win.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                int pmax;
                pmax = (k == 0) ? 255 : 7;
                m_lat[k] += longint'(m_pend[k]);
                if (rsp && !rd && m_pend[k] == 0) m_err[k] = 1;
                m_pend[k] = m_pend[k] + int'(rd) - int'(rsp);
                if (m_pend[k] < 0)    m_pend[k] = 0;
                if (m_pend[k] > pmax) m_pend[k] = pmax;
            end
            m_reads  += longint'(rd);
            m_writes += longint'(wr);
            if (rd) begin
                hit = 0;
                foreach (m_win[j]) if (m_win[j] == req_addr) hit = 1;
                if (hit) m_dup++;
                m_win.push_back(req_addr);
                if (m_win.size() > DUP_N) void'(m_win.pop_front());
            end
        end
    endtask

    task automatic check_model();
        longint unsigned mb, ms, exp_dup;
        mb = (64'd1 << 44) - 1;
        ms = 64'd15;
`ifdef MEM_PERF_DUP_EN
        exp_dup = m_dup;
`else
        exp_dup = 0;
`endif
        chk("big_reads",   reads_b,  m_reads & mb);
        chk("big_writes",  writes_b, m_writes & mb);
        chk("big_latency", lat_b,    m_lat[0] & mb);
        chk("big_dup",     dup_b,    exp_dup & mb);
        chk("big_pending", pend_b,   longint'(m_pend[0]));
        chk("big_err",     err_b,    longint'(m_err[0]));
        chk("small_reads",   reads_s,  m_reads & ms);
        chk("small_writes",  writes_s, m_writes & ms);
        chk("small_latency", lat_s,    m_lat[1] & ms);
        chk("small_dup",     dup_s,    exp_dup & ms);
        chk("small_pending", pend_s,   longint'(m_pend[1]));
        chk("small_err",     err_s,    longint'(m_err[1]));
    endtask

    // Drive one cycle at the negedge, advance the model with the edge, sample 1ns later.
    task automatic cycle(input bit rst, input bit v, input bit r, input bit rw,
                         input logic [AW-1:0] a, input bit rv, input bit rr);
        @(negedge clk);
        reset = rst; req_valid = v; req_ready = r; req_rw = rw;
        req_addr = a; rsp_valid = rv; rsp_ready = rr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit rst, v, r, rw, rv, rr;
        int reads, writes, lat, pend;
        bit err;
    } vec_t;

    vec_t tbl [20];

    initial begin
        reset = 1'b1; req_valid = 0; req_ready = 0; req_rw = 0;
        req_addr = '0; rsp_valid = 0; rsp_ready = 0;

        //           rst v r rw rv rr  reads wr lat pend err
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0,  1, 0,  0, 1, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0,  2, 0,  1, 2, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 0,  3, 0,  3, 3, 0};
        tbl[4]  = '{0, 1, 1, 1, 0, 0,  3, 1,  6, 3, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 0,  3, 2,  9, 3, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0,  3, 2, 12, 3, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 0,  3, 2, 15, 3, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 1,  3, 2, 18, 2, 0};
        tbl[9]  = '{0, 1, 1, 0, 1, 1,  4, 2, 20, 2, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 1,  4, 2, 22, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 1,  4, 2, 23, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 1,  4, 2, 23, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0,  4, 2, 23, 0, 1};
        tbl[14] = '{0, 1, 1, 0, 0, 0,  5, 2, 23, 1, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 1, 1,  0, 0,  0, 0, 1};
        tbl[17] = '{1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0};
        tbl[18] = '{0, 1, 1, 0, 1, 1,  1, 0,  0, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].r, tbl[i].rw, '0, tbl[i].rv, tbl[i].rr);
            chk($sformatf("tbl%0d_reads", i),   reads_b,  longint'(tbl[i].reads));
            chk($sformatf("tbl%0d_writes", i),  writes_b, longint'(tbl[i].writes));
            chk($sformatf("tbl%0d_latency", i), lat_b,    longint'(tbl[i].lat));
            chk($sformatf("tbl%0d_pending", i), pend_b,   longint'(tbl[i].pend));
            chk($sformatf("tbl%0d_err", i),     err_b,    longint'(tbl[i].err));
        end

        // One read, four idle cycles, response: five cycles of one outstanding read.
        cycle(1, 0, 0, 0, '0, 0, 0);
        cycle(0, 1, 1, 0, 26'h10, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, '0, 0, 0);
        cycle(0, 0, 0, 0, '0, 1, 1);
        chk("lat5_latency", lat_b, 64'd5);
        chk("lat5_pending", pend_b, 64'd0);
        chk("lat5_err", err_b, 64'd0);
        check_model();

        // 17 reads: 4-bit counter wraps to 1, 3-bit pending saturates at 7.
        cycle(1, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(0, 1, 1, 0, AW'(i), 0, 0);
        chk("wrap_small_reads", reads_s, 64'd1);
        chk("wrap_big_reads", reads_b, 64'd17);
        chk("sat_small_pending", pend_s, 64'd7);
        chk("sat_big_pending", pend_b, 64'd17);
        check_model();

        cycle(1, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
